// File: rtl/ground_pkg.sv
// Shared constants for the ground strip: geometry, ROM row range and the
// blanking column at which the next row is fetched.
package ground_pkg;
   localparam int WIDTH   = 700;  // ground row length in pixels (ROM word width)
   localparam int X0      = 50;   // first active hc column of the strip
   localparam int Y0      = 400;  // first vc line of the strip (ROM row 0)
   localparam int ROWS    = 10;   // number of ROM rows
   localparam int LOAD_HC = 790;  // next-row request column, inside horizontal blanking
   localparam int OFS_W   = 10;   // scroll offset width, holds 0..WIDTH-1
   localparam int CNT_W   = 11;   // hc/vc counter width
endpackage

// File: rtl/scroll_offset_ctr.sv
// Per-frame horizontal scroll accumulator, kept in 0..WIDTH-1 by a single
// conditional subtract (speed is always far smaller than WIDTH).
module scroll_offset_ctr
   import ground_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             run,
   input  logic [3:0]       speed,
   output logic [OFS_W-1:0] offset
);

   logic [OFS_W:0]   sum;
   logic [OFS_W-1:0] offset_next;

   always_comb begin
      sum = {1'b0, offset} + {{(OFS_W-3){1'b0}}, speed};
      if (sum >= (OFS_W+1)'(WIDTH)) begin
         offset_next = OFS_W'(sum - (OFS_W+1)'(WIDTH));
      end else begin
         offset_next = sum[OFS_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset <= '0;
      end else if (tick && run) begin
         offset <= offset_next;
      end
   end

endmodule

// File: rtl/ground_scroll_renderer.sv
// Fetches the next ground row during horizontal blanking and serialises it into
// a registered per-pixel mask, shifted by a frame-stable scroll offset.
module ground_scroll_renderer
   import ground_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] hc,
   input  logic [CNT_W-1:0] vc,
   input  logic [WIDTH-1:0] row_data,
   output logic [CNT_W-1:0] rom_vc,
   input  logic             frame_tick,
   input  logic             run,
   input  logic [3:0]       speed,
   output logic             pix_on
);

   logic [WIDTH-1:0] row_reg;
   logic             row_valid;
   logic [OFS_W-1:0] offset;
   logic [OFS_W-1:0] line_offset;
   logic [CNT_W-1:0] hc_rel;
   logic [CNT_W-1:0] col_raw;
   logic [CNT_W-1:0] col;
   logic             in_strip;
   logic             col_ok;
   logic [OFS_W-1:0] bit_idx;
   logic             pix_bit;

   scroll_offset_ctr u_offset (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (frame_tick),
      .run    (run),
      .speed  (speed),
      .offset (offset)
   );

   // Both operands are below WIDTH, so one conditional subtract completes the wrap.
   always_comb begin
      hc_rel   = hc - CNT_W'(X0);
      in_strip = (hc >= CNT_W'(X0)) && (hc <= CNT_W'(X0 + WIDTH - 1));
      col_raw  = hc_rel + {1'b0, line_offset};
      col      = (col_raw >= CNT_W'(WIDTH)) ? col_raw - CNT_W'(WIDTH) : col_raw;
      col_ok   = in_strip && (col < CNT_W'(WIDTH));
      bit_idx  = col_ok ? OFS_W'(WIDTH - 1) - col[OFS_W-1:0] : '0;
      pix_bit  = row_reg[bit_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_vc      <= '0;
         row_reg     <= '0;
         row_valid   <= 1'b0;
         line_offset <= '0;
         pix_on      <= 1'b0;
      end else begin
         if (hc == CNT_W'(LOAD_HC)) begin
            rom_vc <= vc + CNT_W'(1);
         end
         // Shadow the offset here so a frame tick never tears a visible line.
         if (hc == CNT_W'(LOAD_HC + 1)) begin
            row_reg     <= row_data;
            row_valid   <= (rom_vc >= CNT_W'(Y0)) && (rom_vc <= CNT_W'(Y0 + ROWS - 1));
            line_offset <= offset;
         end
         pix_on <= row_valid && col_ok && pix_bit;
      end
   end

endmodule
